// File: rtl/level_pkg.sv
// Shared level-progression definitions: FSM state encoding and counter sizing.
package level_pkg;

  localparam logic [1:0] ST_PLAY  = 2'd0;
  localparam logic [1:0] ST_PAUSE = 2'd1;
  localparam logic [1:0] ST_WON   = 2'd2;

  typedef enum logic [1:0] {
    S_PLAY  = ST_PLAY,
    S_PAUSE = ST_PAUSE,
    S_WON   = ST_WON
  } level_state_e;

  // Width needed to count 0..n-1, never below one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/level_progress_ctrl_goal_detector.sv
// Combinational goal check: every hero on the goal tile and score at or above the target.
module goal_detector #(
  parameter int N_HEROES = 2,
  parameter int POS_W    = 12,
  parameter int SCORE_W  = 24,
  parameter int GOAL_X   = 482,
  parameter int GOAL_Y   = 108
) (
  input  logic [N_HEROES*POS_W-1:0] hero_x_pos,
  input  logic [N_HEROES*POS_W-1:0] hero_y_pos,
  input  logic [SCORE_W-1:0]        score,
  input  logic [SCORE_W-1:0]        score_req,
  output logic                      goal_hit
);

  localparam logic [POS_W-1:0] GOAL_X_C = POS_W'(GOAL_X);
  localparam logic [POS_W-1:0] GOAL_Y_C = POS_W'(GOAL_Y);

  logic all_on_s;

  // AND-reduce the per-hero coordinate matches, then qualify with the score.
  always_comb begin
    all_on_s = 1'b1;
    for (int i = 0; i < N_HEROES; i++) begin
      all_on_s = all_on_s & (hero_x_pos[i*POS_W +: POS_W] == GOAL_X_C)
                          & (hero_y_pos[i*POS_W +: POS_W] == GOAL_Y_C);
    end
    goal_hit = all_on_s & (score >= score_req);
  end

endmodule

// File: rtl/level_progress_ctrl.sv
// Level-progression controller: goal hold, level advance, intermission and win handling.
// Optional build macro LEVEL_WRAP_EN: wrap to level 0 after MAX_LEVEL instead of latching a win.
module level_progress_ctrl
  import level_pkg::*;
#(
  parameter int N_HEROES     = 2,
  parameter int POS_W        = 12,
  parameter int SCORE_W      = 24,
  parameter int LEVEL_W      = 10,
  parameter int GOAL_X       = 482,
  parameter int GOAL_Y       = 108,
  parameter int SCORE_STEP   = 1000,
  parameter int HOLD_CYCLES  = 1,
  parameter int PAUSE_CYCLES = 64,
  parameter int MAX_LEVEL    = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SCORE_W-1:0]        score,
  input  logic [N_HEROES*POS_W-1:0] hero_x_pos,
  input  logic [N_HEROES*POS_W-1:0] hero_y_pos,
  output logic [LEVEL_W-1:0]        level,
  output logic                      hero_rst,
  output logic [SCORE_W-1:0]        score_req,
  output logic                      level_busy,
  output logic                      game_won
);

  localparam int HOLD_W  = cnt_width(HOLD_CYCLES);
  localparam int PAUSE_W = cnt_width(PAUSE_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);
  localparam logic [SCORE_W-1:0] STEP_C     = SCORE_W'(SCORE_STEP);

  level_state_e         state_r;
  logic [HOLD_W-1:0]    hold_cnt_r;
  logic [PAUSE_W-1:0]   pause_cnt_r;
  logic                 goal_hit_s;
  logic [SCORE_W:0]     req_sum_s;
  logic [SCORE_W-1:0]   next_req_s;

  goal_detector #(
    .N_HEROES (N_HEROES),
    .POS_W    (POS_W),
    .SCORE_W  (SCORE_W),
    .GOAL_X   (GOAL_X),
    .GOAL_Y   (GOAL_Y)
  ) u_goal_detector (
    .hero_x_pos (hero_x_pos),
    .hero_y_pos (hero_y_pos),
    .score      (score),
    .score_req  (score_req),
    .goal_hit   (goal_hit_s)
  );

  // Next score target, saturating at all-ones instead of wrapping.
  always_comb begin
    req_sum_s = {1'b0, score} + {1'b0, STEP_C};
    if (req_sum_s[SCORE_W]) begin
      next_req_s = {SCORE_W{1'b1}};
    end else begin
      next_req_s = req_sum_s[SCORE_W-1:0];
    end
  end

  // Progression FSM with hold/pause counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_PLAY;
      level       <= {LEVEL_W{1'b0}};
      hero_rst    <= 1'b0;
      score_req   <= STEP_C;
      level_busy  <= 1'b0;
      game_won    <= 1'b0;
      hold_cnt_r  <= {HOLD_W{1'b0}};
      pause_cnt_r <= {PAUSE_W{1'b0}};
    end else begin
      hero_rst <= 1'b0;
`ifdef LEVEL_WRAP_EN
      game_won <= 1'b0;
`endif
      case (state_r)
        S_PLAY: begin
          if (!goal_hit_s) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
          end else if (hold_cnt_r != HOLD_LAST) begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end else begin
            hold_cnt_r <= {HOLD_W{1'b0}};
            hero_rst   <= 1'b1;
            level_busy <= 1'b1;
            if (level != LEVEL_MAX) begin
              level       <= level + LEVEL_W'(1);
              score_req   <= next_req_s;
              pause_cnt_r <= PAUSE_LAST;
              state_r     <= S_PAUSE;
            end else begin
`ifdef LEVEL_WRAP_EN
              level       <= {LEVEL_W{1'b0}};
              game_won    <= 1'b1;
              score_req   <= next_req_s;
              pause_cnt_r <= PAUSE_LAST;
              state_r     <= S_PAUSE;
`else
              game_won    <= 1'b1;
              state_r     <= S_WON;
`endif
            end
          end
        end
        S_PAUSE: begin
          hold_cnt_r <= {HOLD_W{1'b0}};
          if (pause_cnt_r == {PAUSE_W{1'b0}}) begin
            level_busy <= 1'b0;
            state_r    <= S_PLAY;
          end else begin
            pause_cnt_r <= pause_cnt_r - PAUSE_W'(1);
          end
        end
        S_WON: begin
          state_r <= S_WON;
        end
        default: begin
          state_r    <= S_PLAY;
          level_busy <= 1'b0;
          hold_cnt_r <= {HOLD_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_level_progress_ctrl.sv
// Bench: two controller instances (default and HOLD=4/PAUSE=4/MAX=2) checked by table,
// hand sequences and randomized stimulus against a cycle-level behavioural model.
module tb_level_progress_ctrl;

  localparam int NH = 2, PW = 12, SW = 24, LW = 10;
  localparam int GX = 482, GY = 108, STEP = 1000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [SW-1:0]    score_a, score_b;
  logic [NH*PW-1:0] xa, ya, xb, yb;
  logic [LW-1:0]    level_a, level_b;
  logic [SW-1:0]    req_a, req_b;
  logic             hrst_a, hrst_b, busy_a, busy_b, won_a, won_b;

  level_progress_ctrl dut_a (
    .clk(clk), .rst(rst_n), .score(score_a), .hero_x_pos(xa), .hero_y_pos(ya),
    .level(level_a), .hero_rst(hrst_a), .score_req(req_a), .level_busy(busy_a), .game_won(won_a)
  );

  level_progress_ctrl #(.HOLD_CYCLES(4), .PAUSE_CYCLES(4), .MAX_LEVEL(2)) dut_b (
    .clk(clk), .rst(rst_n), .score(score_b), .hero_x_pos(xb), .hero_y_pos(yb),
    .level(level_b), .hero_rst(hrst_b), .score_req(req_b), .level_busy(busy_b), .game_won(won_b)
  );

  int checks = 0, passes = 0;
  int pulses[2], busy_cnt[2];

  // Behavioural model state per instance.
  int m_level[2], m_req[2], m_hrst[2], m_busy[2], m_won[2], m_over[2], m_streak[2], m_pleft[2];

  function automatic int hold_of(input int k);  return (k == 0) ? 1 : 4;   endfunction
  function automatic int pause_of(input int k); return (k == 0) ? 64 : 4;  endfunction
  function automatic int max_of(input int k);   return (k == 0) ? 15 : 2;  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic bit all_on(input logic [NH*PW-1:0] x, input logic [NH*PW-1:0] y);
    bit r = 1'b1;
    for (int i = 0; i < NH; i++)
      if (int'(x[i*PW +: PW]) != GX || int'(y[i*PW +: PW]) != GY) r = 1'b0;
    return r;
  endfunction

  function automatic int sat_add(input int s);
    longint t = longint'(s) + STEP;
    return (t > 64'd16777215) ? 16777215 : int'(t);
  endfunction

  task automatic model_reset(input int k);
    m_level[k] = 0; m_req[k] = STEP; m_hrst[k] = 0; m_busy[k] = 0;
    m_won[k] = 0; m_over[k] = 0; m_streak[k] = 0; m_pleft[k] = 0;
  endtask

  // One clock edge of the specified behaviour, counted in cycles rather than counter values.
  task automatic model_step(input int k, input bit on, input int sc);
    if (!rst_n) begin model_reset(k); return; end
    m_hrst[k] = 0;
`ifdef LEVEL_WRAP_EN
    m_won[k] = 0;
`endif
    if (m_over[k] != 0) return;
    if (m_pleft[k] > 0) begin
      m_pleft[k]--;
      if (m_pleft[k] == 0) m_busy[k] = 0;
      m_streak[k] = 0;
      return;
    end
    if (!(on && sc >= m_req[k])) begin m_streak[k] = 0; return; end
    m_streak[k]++;
    if (m_streak[k] < hold_of(k)) return;
    m_streak[k] = 0; m_hrst[k] = 1; m_busy[k] = 1;
    if (m_level[k] < max_of(k)) begin
      m_level[k]++; m_req[k] = sat_add(sc); m_pleft[k] = pause_of(k);
    end else begin
`ifdef LEVEL_WRAP_EN
      m_level[k] = 0; m_won[k] = 1; m_req[k] = sat_add(sc); m_pleft[k] = pause_of(k);
`else
      m_won[k] = 1; m_over[k] = 1;
`endif
    end
  endtask

  task automatic compare_all();
    check("level_a", int'(level_a), m_level[0]); check("req_a", int'(req_a), m_req[0]);
    check("hrst_a", int'(hrst_a), m_hrst[0]);    check("busy_a", int'(busy_a), m_busy[0]);
    check("won_a", int'(won_a), m_won[0]);
    check("level_b", int'(level_b), m_level[1]); check("req_b", int'(req_b), m_req[1]);
    check("hrst_b", int'(hrst_b), m_hrst[1]);    check("busy_b", int'(busy_b), m_busy[1]);
    check("won_b", int'(won_b), m_won[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0, all_on(xa, ya), int'(score_a));
    model_step(1, all_on(xb, yb), int'(score_b));
    @(negedge clk);
    compare_all();
    pulses[0] += int'(hrst_a); busy_cnt[0] += int'(busy_a);
    pulses[1] += int'(hrst_b); busy_cnt[1] += int'(busy_b);
  endtask

  // mask bit i set puts hero i on the goal; a cleared bit moves x or y off by a varying amount.
  task automatic place(input int k, input logic [1:0] mask, input int sc);
    logic [NH*PW-1:0] x, y;
    for (int i = 0; i < NH; i++) begin
      x[i*PW +: PW] = PW'(GX);
      y[i*PW +: PW] = PW'(GY);
      if (!mask[i]) begin
        if ($urandom_range(0, 1) == 0) x[i*PW +: PW] = PW'(GX + 1 + $urandom_range(0, 50));
        else                           y[i*PW +: PW] = PW'(GY - 1 - $urandom_range(0, 50));
      end
    end
    if (k == 0) begin xa = x; ya = y; score_a = SW'(sc); end
    else        begin xb = x; yb = y; score_b = SW'(sc); end
  endtask

  // Asynchronous reset mid-low-phase; outputs must drop before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_level_a", int'(level_a), 0); check("rst_req_a", int'(req_a), STEP);
    check("rst_hrst_a", int'(hrst_a), 0);   check("rst_busy_a", int'(busy_a), 0);
    check("rst_won_a", int'(won_a), 0);
    check("rst_level_b", int'(level_b), 0); check("rst_busy_b", int'(busy_b), 0);
    check("rst_won_b", int'(won_b), 0);
    model_reset(0); model_reset(1);
    repeat (2) cycle();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int         dut;
    logic [1:0] mask;
    int         score, n;
    int         e_level, e_req, e_busy, e_won, e_pulses, e_busycnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int d, input logic [1:0] m, input int s, input int n,
                              input int el, input int er, input int eb, input int ew,
                              input int ep, input int ebc);
    vec_t v;
    v.dut = d; v.mask = m; v.score = s; v.n = n; v.e_level = el; v.e_req = er;
    v.e_busy = eb; v.e_won = ew; v.e_pulses = ep; v.e_busycnt = ebc;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0;
    place(0, 2'b00, 0); place(1, 2'b00, 0);
    model_reset(0); model_reset(1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // dut, mask, score, cycles -> level, req, busy, won, pulses, busy cycles in row
    tbl.push_back(mk(0, 2'b00, 0,    100, 0, 1000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b11, 1500, 1,   1, 2500, 1, 0, 1, 1));
    tbl.push_back(mk(0, 2'b11, 5000, 63,  1, 2500, 1, 0, 0, 63));
    tbl.push_back(mk(0, 2'b00, 5000, 1,   1, 2500, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b01, 9000, 5,   1, 2500, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b10, 9000, 5,   1, 2500, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2499, 5,   1, 2500, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2500, 1,   2, 3500, 1, 0, 1, 1));
    tbl.push_back(mk(1, 2'b11, 1200, 3,   0, 1000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b00, 1200, 1,   0, 1000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b11, 1200, 3,   0, 1000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b11, 1200, 1,   1, 2200, 1, 0, 1, 1));
    tbl.push_back(mk(1, 2'b00, 0,    4,   1, 2200, 0, 0, 0, 3));
    tbl.push_back(mk(1, 2'b11, 3000, 4,   2, 4000, 1, 0, 1, 1));
    tbl.push_back(mk(1, 2'b00, 0,    4,   2, 4000, 0, 0, 0, 3));
`ifdef LEVEL_WRAP_EN
    tbl.push_back(mk(1, 2'b11, 5000, 4,   0, 6000, 1, 1, 1, 1));
    tbl.push_back(mk(1, 2'b11, 5000, 10,  0, 6000, 0, 0, 0, 3));
`else
    tbl.push_back(mk(1, 2'b11, 5000, 4,   2, 4000, 1, 1, 1, 1));
    tbl.push_back(mk(1, 2'b11, 5000, 10,  2, 4000, 1, 1, 0, 10));
`endif

    foreach (tbl[r]) begin
      place(tbl[r].dut, tbl[r].mask, tbl[r].score);
      place(1 - tbl[r].dut, 2'b00, 0);
      pulses[0] = 0; pulses[1] = 0; busy_cnt[0] = 0; busy_cnt[1] = 0;
      repeat (tbl[r].n) cycle();
      if (tbl[r].dut == 0) begin
        check($sformatf("row%0d_level", r), int'(level_a), tbl[r].e_level);
        check($sformatf("row%0d_req", r), int'(req_a), tbl[r].e_req);
        check($sformatf("row%0d_busy", r), int'(busy_a), tbl[r].e_busy);
        check($sformatf("row%0d_won", r), int'(won_a), tbl[r].e_won);
      end else begin
        check($sformatf("row%0d_level", r), int'(level_b), tbl[r].e_level);
        check($sformatf("row%0d_req", r), int'(req_b), tbl[r].e_req);
        check($sformatf("row%0d_busy", r), int'(busy_b), tbl[r].e_busy);
        check($sformatf("row%0d_won", r), int'(won_b), tbl[r].e_won);
      end
      check($sformatf("row%0d_pulses", r), pulses[tbl[r].dut], tbl[r].e_pulses);
      check($sformatf("row%0d_busycnt", r), busy_cnt[tbl[r].dut], tbl[r].e_busycnt);
    end

    // Reset ten cycles into an intermission, then a fresh advance to level 1.
    do_reset();
    place(0, 2'b11, 1500); place(1, 2'b00, 0);
    cycle();
    check("pre_rst_level", int'(level_a), 1);
    place(0, 2'b00, 0);
    repeat (10) cycle();
    check("pre_rst_busy", int'(busy_a), 1);
    do_reset();
    place(0, 2'b00, 0);
    pulses[0] = 0;
    repeat (3) cycle();
    check("release_no_pulse", pulses[0], 0);
    place(0, 2'b11, 1500);
    cycle();
    check("post_rst_level", int'(level_a), 1);
    check("post_rst_hrst", int'(hrst_a), 1);

    // Randomized stimulus, scores hovering around each instance's current target.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        logic [1:0] m;
        int s;
        m = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'(($urandom_range(0, 3)));
        s = m_req[k] + int'($urandom_range(0, 600)) - 300;
        if (s < 0) s = 0;
        place(k, m, s);
      end
      if ($urandom_range(0, 599) == 0) do_reset();
      else cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
